// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - WS2812B transmitter shared timing defaults, FSM state type and GRB field indices
package ws2812b_pkg;

  // Default bit timing in clk cycles (50 MHz clock).
  localparam int T0H_DEF  = 20;
  localparam int T1H_DEF  = 40;
  localparam int TBIT_DEF = 63;
  localparam int TRST_DEF = 3000;

  // Pixel layout {G,R,B}; the green MSB is the first bit on the wire.
  localparam int PIX_W = 24;
  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } tx_state_t;

  // Larger of two timing parameters; used to size the shared counter width.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812b_tx_if.sv
// rtl/ws2812b_tx_if.sv - pixel stream handshake interface (master drives pixels, slave returns ready)
interface ws2812b_tx_if;
  import ws2812b_pkg::*;

  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_last;
  logic             pix_ready;

  modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
  modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);

endinterface

// File: rtl/ws2812b_bit_encoder.sv
// rtl/ws2812b_bit_encoder.sv - single WS2812B bit timer: registered high phase, then low phase to TBIT
module ws2812b_bit_encoder #(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 63,
  parameter int CW   = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_in,
  output logic dout,
  output logic hi_end,
  output logic bit_end
);

  localparam logic [CW-1:0] T0H_M1  = CW'(T0H - 1);
  localparam logic [CW-1:0] T1H_M1  = CW'(T1H - 1);
  localparam logic [CW-1:0] TBIT_M1 = CW'(TBIT - 1);

  logic          active;
  logic          bit_q;
  logic [CW-1:0] cnt;

  // hi_end marks the last high cycle; bit_end marks the last cycle of the
  // bit, so a start issued in that cycle chains the next bit seamlessly.
  assign hi_end  = active && dout && (cnt == (bit_q ? T1H_M1 : T0H_M1));
  assign bit_end = active && (cnt == TBIT_M1);

  // Phase counter and line register; start always wins so bits abut exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      bit_q  <= 1'b0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      bit_q  <= bit_in;
      cnt    <= '0;
      dout   <= 1'b1;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      if (hi_end) begin
        dout <= 1'b0;
      end
      if (bit_end) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ws2812b_tx.sv
// rtl/ws2812b_tx.sv - WS2812B serial transmitter; optional WS2812B_TX_STATS_EN adds frame_pixels
module ws2812b_tx
  import ws2812b_pkg::*;
#(
  parameter int T0H  = T0H_DEF,
  parameter int T1H  = T1H_DEF,
  parameter int TBIT = TBIT_DEF,
  parameter int TRST = TRST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ws2812b_tx_if.slave       pix,
  output logic              dout,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
`ifdef WS2812B_TX_STATS_EN
  ,
  output logic [15:0]       frame_pixels
`endif
);

  localparam int CW  = $clog2(max_int(TBIT, TRST));
  localparam int BCW = $clog2(PIX_W);

  localparam logic [CW-1:0]  TRST_M1   = CW'(TRST - 1);
  localparam logic [BCW-1:0] FIRST_BIT = BCW'(G_MSB);

  tx_state_t state, state_n;

  logic [PIX_W-1:0] hold_data;
  logic             hold_last;
  logic             hold_full;
  logic [PIX_W-1:0] shifter;
  logic             last_q;
  logic [BCW-1:0]   bit_cnt;
  logic [CW-1:0]    gap_cnt;

  logic accept;
  logic load;
  logic shift;
  logic start;
  logic enc_bit;
  logic enter_gap;
  logic set_underrun;
  logic gap_end;
  logic hi_end;
  logic bit_end;

  assign pix.pix_ready = !hold_full;
  assign accept        = pix.pix_valid && !hold_full;
  assign busy          = (state != IDLE) || hold_full;

  ws2812b_bit_encoder #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT),
    .CW   (CW)
  ) u_enc (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bit_in  (enc_bit),
    .dout    (dout),
    .hi_end  (hi_end),
    .bit_end (bit_end)
  );

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and per-cycle control: loads, bit chaining, underrun and gap exit.
  always_comb begin
    state_n      = state;
    load         = 1'b0;
    shift        = 1'b0;
    start        = 1'b0;
    enc_bit      = 1'b0;
    enter_gap    = 1'b0;
    set_underrun = 1'b0;
    gap_end      = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          start   = 1'b1;
          enc_bit = hold_data[G_MSB];
          state_n = BIT_HI;
        end
      end
      BIT_HI: begin
        if (hi_end) begin
          state_n = BIT_LO;
        end
      end
      BIT_LO: begin
        if (bit_end) begin
          if (bit_cnt != '0) begin
            shift   = 1'b1;
            start   = 1'b1;
            enc_bit = shifter[G_MSB-1];
            state_n = BIT_HI;
          end else if (last_q) begin
            enter_gap = 1'b1;
            state_n   = GAP;
          end else if (hold_full) begin
            load    = 1'b1;
            start   = 1'b1;
            enc_bit = hold_data[G_MSB];
            state_n = BIT_HI;
          end else begin
            set_underrun = 1'b1;
            enter_gap    = 1'b1;
            state_n      = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == TRST_M1) begin
          gap_end = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register, shifter, gap timer and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      shifter    <= '0;
      last_q     <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= gap_end;
      // Ready is low while full, so an accept never coincides with a load.
      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
        hold_data <= pix.pix_data;
        hold_last <= pix.pix_last;
      end
      if (load) begin
        shifter <= hold_data;
        last_q  <= hold_last;
        bit_cnt <= FIRST_BIT;
      end else if (shift) begin
        shifter <= {shifter[PIX_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (enter_gap) begin
        gap_cnt <= '0;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      if (set_underrun) begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef WS2812B_TX_STATS_EN
  logic [15:0] pix_cnt;

  // Count pixels loaded in the current frame; publish alongside frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt      <= '0;
      frame_pixels <= '0;
    end else if (gap_end) begin
      frame_pixels <= pix_cnt;
      pix_cnt      <= '0;
    end else if (load && (pix_cnt != 16'hFFFF)) begin
      pix_cnt <= pix_cnt + 1'b1;
    end
  end
`endif

endmodule
